// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions used by the router local port and its slot
// registers.
//   DATA_WIDTH : packet width; the top bit carries the virtual channel
//   VC_BIT     : index of the VC bit inside a packet
//   vc_t       : virtual-channel identifier (even / odd)
// ---------------------------------------------------------------------------
package noc_pkg;

  parameter int DATA_WIDTH = 64;
  localparam int VC_BIT = DATA_WIDTH - 1;

  typedef enum logic {
    VC_EVEN = 1'b0,
    VC_ODD  = 1'b1
  } vc_t;

endpackage

// File: rtl/router_local_port_if.sv
// ---------------------------------------------------------------------------
// router_local_port_if
// Bundles the NIC link handshakes and the switch-side offer/eject signals
// of the router local port.
//   NIC link   : nic_so/nic_ro/nic_do (injection), nic_si/nic_ri/nic_di
//                (ejection)
//   Switch side: sw_req/sw_data/sw_gnt (offer), sw_we/sw_wdata/sw_full
//                (ejection writes)
// Modports:
//   slave  : the router local port itself
//   master : the surrounding NIC + switch environment
// ---------------------------------------------------------------------------
interface router_local_port_if
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH
);

  logic                  nic_so;
  logic                  nic_ro;
  logic [DATA_WIDTH-1:0] nic_do;
  logic                  nic_si;
  logic                  nic_ri;
  logic [DATA_WIDTH-1:0] nic_di;
  logic                  sw_req;
  logic [DATA_WIDTH-1:0] sw_data;
  logic                  sw_gnt;
  logic                  sw_we;
  logic [DATA_WIDTH-1:0] sw_wdata;
  logic [1:0]            sw_full;

  modport slave (
    input  nic_so, nic_do, nic_ri, sw_gnt, sw_we, sw_wdata,
    output nic_ro, nic_si, nic_di, sw_req, sw_data, sw_full
  );

  modport master (
    output nic_so, nic_do, nic_ri, sw_gnt, sw_we, sw_wdata,
    input  nic_ro, nic_si, nic_di, sw_req, sw_data, sw_full
  );

endinterface

// File: rtl/router_vc_slot.sv
// ---------------------------------------------------------------------------
// router_vc_slot
// One-entry packet register with a full flag.
//   clk, reset : clock, synchronous active-high reset
//   we_i       : write request; only honoured while the slot is empty
//   clr_i      : drain, clears the full flag
//   data_i     : packet to store
//   full_o     : slot holds a packet
//   data_o     : stored packet
// ---------------------------------------------------------------------------
module router_vc_slot
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;

  // A write into an occupied slot is dropped so a stored packet is never
  // overwritten. Fill and drain of one slot happen on opposite polarities,
  // so we_i and clr_i never need arbitrating against each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (we_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/router_local_port.sv
// ---------------------------------------------------------------------------
// router_local_port
// Router-side endpoint of the NIC<->router link. Holds one even and one odd
// VC slot per direction and moves packets under the polarity rule: at
// polarity p the NIC link transfers VC ~p while the switch transfers VC p.
//   clk, reset : clock, synchronous active-high reset
//   link       : NIC link and switch signals (slave modport)
//   polarity   : link polarity, toggles every cycle outside reset
//   inj_cnt    : packets accepted from the NIC (wraps)
//   ej_cnt     : packets delivered to the NIC (wraps)
// ---------------------------------------------------------------------------
module router_local_port
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  router_local_port_if.slave link,
  output logic        polarity,
  output logic [15:0] inj_cnt,
  output logic [15:0] ej_cnt
);

  logic                  polarity_q;
  logic                  polarity_d;
  logic [15:0]           injCnt_q;
  logic [15:0]           injCnt_d;
  logic [15:0]           ejCnt_q;
  logic [15:0]           ejCnt_d;

  vc_t                   linkVc;
  vc_t                   swVc;
  logic                  nicAccept;

  logic [1:0]            injWe;
  logic [1:0]            injClr;
  logic [1:0]            injFull;
  logic [DATA_WIDTH-1:0] injData [2];
  logic [1:0]            ejWe;
  logic [1:0]            ejClr;
  logic [1:0]            ejFull;
  logic [DATA_WIDTH-1:0] ejData [2];

  // Four identical slots: injection (NIC -> switch) and ejection
  // (switch -> NIC), one per VC.
  for (genvar i = 0; i < 2; i++) begin : gSlot
    router_vc_slot #(.DATA_WIDTH(DATA_WIDTH)) uInj (
      .clk    (clk),
      .reset  (reset),
      .we_i   (injWe[i]),
      .clr_i  (injClr[i]),
      .data_i (link.nic_do),
      .full_o (injFull[i]),
      .data_o (injData[i])
    );
    router_vc_slot #(.DATA_WIDTH(DATA_WIDTH)) uEj (
      .clk    (clk),
      .reset  (reset),
      .we_i   (ejWe[i]),
      .clr_i  (ejClr[i]),
      .data_i (link.sw_wdata),
      .full_o (ejFull[i]),
      .data_o (ejData[i])
    );
  end

  // Steering: the link side always works on VC ~polarity and the switch
  // side on VC polarity. Handshake outputs come only from registers (plus
  // nic_ri for nic_si) and are held low during reset.
  always_comb begin
    linkVc       = vc_t'(~polarity_q);
    swVc         = vc_t'(polarity_q);
    link.nic_ro  = ~reset & ~injFull[linkVc];
    link.sw_req  = ~reset & injFull[swVc];
    link.sw_data = injData[swVc];
    link.nic_si  = ~reset & ejFull[linkVc] & link.nic_ri;
    link.nic_di  = ejData[linkVc];
    link.sw_full = ejFull;
    nicAccept    = link.nic_so & link.nic_ro;
    injWe        = nicAccept ? (2'b01 << linkVc) : 2'b00;
    injClr       = (link.sw_gnt & link.sw_req) ? (2'b01 << swVc) : 2'b00;
    ejWe         = link.sw_we ? (2'b01 << swVc) : 2'b00;
    ejClr        = link.nic_si ? (2'b01 << linkVc) : 2'b00;
  end

  // Next-state for the polarity flop and the wrapping transfer counters.
  always_comb begin
    polarity_d = ~polarity_q;
    injCnt_d   = nicAccept ? injCnt_q + 16'd1 : injCnt_q;
    ejCnt_d    = link.nic_si ? ejCnt_q + 16'd1 : ejCnt_q;
  end

  // Polarity starts at 0 on the first cycle after reset and toggles on
  // every edge thereafter.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity_q <= 1'b0;
      injCnt_q   <= '0;
      ejCnt_q    <= '0;
    end else begin
      polarity_q <= polarity_d;
      injCnt_q   <= injCnt_d;
      ejCnt_q    <= ejCnt_d;
    end
  end

  assign polarity = polarity_q;
  assign inj_cnt  = injCnt_q;
  assign ej_cnt   = ejCnt_q;

endmodule

// File: doc/router_local_port.md
# router_local_port

Router-side endpoint of the NIC↔router link: the far end of the NIC's net_si/net_ri/net_di and net_so/net_ro/net_do handshakes. It sources the polarity signal and holds one-entry even/odd virtual-channel (VC) slots in each direction. It moves packets between the NIC link and the router's internal switch under the polarity rule: at polarity p, the link transfers VC ~p and the switch transfers VC p. It sits inside each router, on the local port.

## Interface
- DATA_WIDTH, 64, packet width; bit DATA_WIDTH-1 is the VC bit
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- polarity  out  1  link polarity, drives the NIC's net_polarity
- nic_so  in  1  send from NIC (NIC net_so)
- nic_ro  out  1  ready to NIC (NIC net_ro)
- nic_do  in  DATA_WIDTH  injected packet (NIC net_do)
- nic_si  out  1  send to NIC (NIC net_si)
- nic_ri  in  1  ready from NIC (NIC net_ri)
- nic_di  out  DATA_WIDTH  ejected packet (NIC net_di)
- sw_req  out  1  injection slot of VC=polarity holds a packet
- sw_data  out  DATA_WIDTH  packet offered to switch
- sw_gnt  in  1  switch takes sw_data this cycle
- sw_we  in  1  switch writes an ejection packet
- sw_wdata  in  DATA_WIDTH  ejection packet from switch
- sw_full  out  2  ejection slot full flags, [0]=even VC, [1]=odd VC
- inj_cnt  out  16  packets accepted from NIC, wraps
- ej_cnt  out  16  packets delivered to NIC, wraps

## Operation
- Reset:
  - polarity=0; all four slot full flags=0; slot data=0; counters=0.
  - While reset is high, nic_ro, nic_si and sw_req are forced to 0.
- Polarity: a flop that toggles every cycle outside reset (0,1,0,…) starting with the first cycle after reset.
- Injection slots inj[0], inj[1]:
  - nic_ro = ~inj_full[~polarity].
  - When nic_so & nic_ro: nic_do is written into inj[~polarity], its full flag is set, and inj_cnt increments.
  - The NIC only asserts nic_so for a packet whose VC bit equals ~polarity, so nic_do's VC bit is not re-checked.
- Switch offer:
  - sw_req = inj_full[polarity]; sw_data = inj[polarity].
  - sw_gnt & sw_req clears inj_full[polarity]. sw_gnt with sw_req=0 is ignored.
- Ejection slots ej[0], ej[1]:
  - sw_we writes sw_wdata into ej[polarity] and sets its flag.
  - A write to a full slot is ignored: no overwrite, data lost. The switch must check sw_full.
  - sw_full is the registered flags.
- NIC delivery:
  - nic_di = ej[~polarity]; nic_si = ej_full[~polarity] & nic_ri.
  - When nic_si=1, the transfer occurs: ej_full[~polarity] clears and ej_cnt increments.
- Fill and drain of the same slot never coincide, because they occur on opposite polarities. No same-slot arbitration is needed.
- Reset mid-operation: all packets in the slots are discarded and the counters clear.

## Timing
- All state is updated on posedge clk.
- nic_ro, nic_si, sw_req, sw_data and nic_di are combinational from registers, plus nic_ri for nic_si. There is no comb path from nic_so to nic_ro.
- Minimum NIC→switch latency is 1 cycle: accepted at polarity p, the packet sits in slot ~p, which is offered on the next cycle.
- Minimum switch→NIC latency is 1 cycle.
- Sustained throughput per direction is 1 packet/cycle, alternating VCs.
- Counters wrap from 16'hFFFF to 0.

## Structure
- Shared package `noc_pkg`:
  - DATA_WIDTH default 64
  - VC_BIT = DATA_WIDTH-1
  - vc_t (1-bit) with VC_EVEN=0, VC_ODD=1
- Sub-module `router_vc_slot`: a one-entry register with full flag, plus we/clr/data ports and synchronous reset. Instantiated four times (inj[0..1], ej[0..1]).
- Polarity flop, muxes and counters are in the top.

## Test plan
- Reset held 3 cycles then released → polarity toggles 0,1,0…; nic_ro=1 from the first post-reset cycle; sw_full=2'b00; inj_cnt=0; nic_si=0.
- Inject 64'h8000_0000_0000_00AA (VC1) with nic_so=1 at polarity 0 → inj[1] full; next cycle (polarity 1) sw_req=1 with that data; sw_gnt=1 clears it; inj_cnt=1.
- Two back-to-back injections, VC1 at polarity 0 and VC0 at polarity 1, with sw_gnt tied 0 → both slots full; nic_ro=0 on every cycle; third nic_so is not accepted; inj_cnt=2.
- sw_we with 64'h0000_0000_0000_0055 at polarity 0 → sw_full[0]=1; next cycle with nic_ri=1 → nic_si=1 and nic_di=0x55; following cycle sw_full[0]=0; ej_cnt=1.
- Ejection slot full and nic_ri=0 for 4 cycles → nic_si stays 0; a second sw_we into that slot is ignored and nic_di keeps the original value; delivery on the first matching polarity after nic_ri rises.
- Reset asserted while all four slots are full → next cycle all flags 0, sw_req=0, counters=0, polarity=0.
